fifo_burst_consumer: RTL and testbench

Drains multi-character entries from the keyboard-side UART FIFO and serialises them onto the UART transmitter one character at a time. It is the parametrised successor to the fixed 7-slot consumer, with configurable slot count, character width and send order. It also adds zero-length/over-length handling, a race-free busy handshake, status pulses and an optional inter-character gap. It sits between the FIFO read port and the UART TX start/busy interface.

---
 rtl/fifo_burst_consumer.sv | 192 +++++++++++++++++++
 tb/tb_fifo_burst_consumer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_burst_consumer.sv
// fifo_burst_consumer: pops one multi-character entry at a time from the keyboard-side FIFO and
// feeds its characters to the UART transmitter, one start strobe per character.
// Optional inter-character gap: compile with FIFO_CONSUMER_GAP_EN defined to add the GAP state
// and its 8-bit counter; without it GAP_CYCLES has no effect.
module fifo_burst_consumer #(
    parameter int unsigned MAX_CHARS  = 8,
    parameter int unsigned CHAR_W     = 8,
    parameter int unsigned LEN_W      = $clog2(MAX_CHARS + 1),
    parameter int unsigned MSB_FIRST  = 1,
    parameter int unsigned GAP_CYCLES = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        fifoEmpty,
    input  logic [MAX_CHARS*CHAR_W-1:0] fifoOutData,
    input  logic [LEN_W-1:0]            fifoOutLen,
    input  logic                        uartBusy,
    output logic                        fifoReadRequest,
    output logic                        uartStartSend,
    output logic [CHAR_W-1:0]           uartDataToSend,
    output logic                        active,
    output logic                        packetDone,
    output logic                        dropPulse
);

    localparam int unsigned IdxW = (MAX_CHARS > 1) ? $clog2(MAX_CHARS) : 1;
    localparam int unsigned CntW = $clog2(MAX_CHARS + 1);
    localparam int unsigned PayW = MAX_CHARS * CHAR_W;

`ifdef FIFO_CONSUMER_GAP_EN
    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StRead  = 3'd1,
        StSend  = 3'd2,
        StGuard = 3'd3,
        StWait  = 3'd4,
        StGap   = 3'd5
    } state_e;
`else
    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StRead  = 3'd1,
        StSend  = 3'd2,
        StGuard = 3'd3,
        StWait  = 3'd4
    } state_e;
`endif

    state_e            state_q, state_d;
    logic [PayW-1:0]   payload_q, payload_d;
    logic [IdxW-1:0]   index_q, index_d;
    logic [CntW-1:0]   remain_q, remain_d;
    logic [CntW-1:0]   eff_len;
    logic [CHAR_W-1:0] cur_char;

`ifdef FIFO_CONSUMER_GAP_EN
    logic [7:0]        gap_q, gap_d;
`else
    // GAP_CYCLES is only meaningful when the gap feature is compiled in.
    logic              unused_gap_cycles;
    assign unused_gap_cycles = (GAP_CYCLES != 0);
`endif

    // Clamp the advertised length to the number of slots actually present in the entry.
    always_comb begin
        if (32'(fifoOutLen) > MAX_CHARS) begin
            eff_len = CntW'(MAX_CHARS);
        end else begin
            eff_len = CntW'(fifoOutLen);
        end
    end

    assign cur_char = payload_q[index_q * CHAR_W +: CHAR_W];

    // State and datapath registers; an in-flight entry is simply dropped on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            payload_q <= '0;
            index_q   <= '0;
            remain_q  <= '0;
`ifdef FIFO_CONSUMER_GAP_EN
            gap_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            payload_q <= payload_d;
            index_q   <= index_d;
            remain_q  <= remain_d;
`ifdef FIFO_CONSUMER_GAP_EN
            gap_q     <= gap_d;
`endif
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d   = state_q;
        payload_d = payload_q;
        index_d   = index_q;
        remain_d  = remain_q;
`ifdef FIFO_CONSUMER_GAP_EN
        gap_d     = gap_q;
`endif
        case (state_q)
            StIdle: begin
                if (!fifoEmpty) begin
                    state_d = StRead;
                end
            end
            StRead: begin
                payload_d = fifoOutData;
                if (eff_len == '0) begin
                    state_d = StIdle;
                end else begin
                    remain_d = eff_len;
                    index_d  = (MSB_FIRST != 0) ? IdxW'(eff_len - CntW'(1)) : '0;
                    state_d  = StSend;
                end
            end
            StSend: begin
                state_d = StGuard;
            end
            // Busy may not have risen yet in the cycle after the start strobe; skip it.
            StGuard: begin
                state_d = StWait;
            end
            StWait: begin
                if (!uartBusy) begin
                    if (remain_q == CntW'(1)) begin
                        state_d = StIdle;
                    end else begin
                        remain_d = remain_q - CntW'(1);
                        index_d  = (MSB_FIRST != 0) ? index_q - IdxW'(1) : index_q + IdxW'(1);
`ifdef FIFO_CONSUMER_GAP_EN
                        if (GAP_CYCLES > 0) begin
                            gap_d   = 8'(GAP_CYCLES - 1);
                            state_d = StGap;
                        end else begin
                            state_d = StSend;
                        end
`else
                        state_d = StSend;
`endif
                    end
                end
            end
`ifdef FIFO_CONSUMER_GAP_EN
            // Stay here for exactly GAP_CYCLES cycles before the next start.
            StGap: begin
                if (gap_q == '0) begin
                    state_d = StSend;
                end else begin
                    gap_d = gap_q - 8'd1;
                end
            end
`endif
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Output decode. The read request is gated by rst so nothing pops while in reset;
    // dropPulse and packetDone follow the length/busy inputs in the deciding cycle.
    always_comb begin
        fifoReadRequest = 1'b0;
        uartStartSend   = 1'b0;
        uartDataToSend  = '0;
        packetDone      = 1'b0;
        dropPulse       = 1'b0;
        active          = (state_q != StIdle);
        case (state_q)
            StIdle: begin
                fifoReadRequest = !rst && !fifoEmpty;
            end
            StRead: begin
                dropPulse = (eff_len == '0);
            end
            StSend: begin
                uartStartSend  = 1'b1;
                uartDataToSend = cur_char;
            end
            StWait: begin
                packetDone = !uartBusy && (remain_q == CntW'(1));
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_fifo_burst_consumer.sv
// tb_fifo_burst_consumer: directed bench for fifo_burst_consumer. Main instance is MSB-first with a
// widened length field; a second instance checks LSB-first ordering.
module tb_fifo_burst_consumer;

    localparam int unsigned LenW = 5;
`ifdef FIFO_CONSUMER_GAP_EN
    localparam int Gap = 5;
`else
    localparam int Gap = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- main instance (MSB first) ----------------
    logic            fifo_empty, uart_busy, rd_req, start, active, done, drop;
    logic [7:0]      tx_data;
    logic [63:0]     fifo_data_q = '0;
    logic [LenW-1:0] fifo_len_q  = '0;
    logic [63:0]     ent_data [32];
    logic [LenW-1:0] ent_len  [32];
    int wr_ptr = 0;
    int rd_ptr = 0;
    int busy_len = 4;
    int busy_cnt = 0;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign uart_busy  = (busy_cnt > 0);

    // FIFO read port model and UART busy model
    always @(posedge clk) begin
        if (rd_req) begin
            fifo_data_q <= ent_data[rd_ptr % 32];
            fifo_len_q  <= ent_len[rd_ptr % 32];
            rd_ptr      <= rd_ptr + 1;
        end
        if (start) busy_cnt <= busy_len;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    end

    fifo_burst_consumer #(
        .MAX_CHARS (8),
        .CHAR_W    (8),
        .LEN_W     (LenW),
        .MSB_FIRST (1),
        .GAP_CYCLES(5)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .fifoEmpty      (fifo_empty),
        .fifoOutData    (fifo_data_q),
        .fifoOutLen     (fifo_len_q),
        .uartBusy       (uart_busy),
        .fifoReadRequest(rd_req),
        .uartStartSend  (start),
        .uartDataToSend (tx_data),
        .active         (active),
        .packetDone     (done),
        .dropPulse      (drop)
    );

    int         st_cyc [64];
    logic [7:0] st_dat [64];
    int         dn_cyc [64];
    int         dr_cyc [64];
    int         rd_cyc [64];
    int n_st = 0, n_dn = 0, n_dr = 0, n_rd = 0, n_nz = 0;

    // Event log, sampled mid-cycle
    always @(negedge clk) begin
        if (start && n_st < 64) begin
            st_cyc[n_st] <= cyc;
            st_dat[n_st] <= tx_data;
            n_st <= n_st + 1;
        end
        if (done && n_dn < 64) begin dn_cyc[n_dn] <= cyc; n_dn <= n_dn + 1; end
        if (drop && n_dr < 64) begin dr_cyc[n_dr] <= cyc; n_dr <= n_dr + 1; end
        if (rd_req && n_rd < 64) begin rd_cyc[n_rd] <= cyc; n_rd <= n_rd + 1; end
        if (!start && tx_data != 8'h00) n_nz <= n_nz + 1;
    end

    // ---------------- second instance (LSB first, busy never asserted) ----------------
    logic       b_empty, b_req, b_start, b_active, b_done, b_drop;
    logic [7:0] b_data;
    int b_push = 0, b_pop = 0;
    assign b_empty = (b_push == b_pop);
    always @(posedge clk) if (b_req) b_pop <= b_pop + 1;

    fifo_burst_consumer #(
        .MAX_CHARS(8),
        .CHAR_W   (8),
        .MSB_FIRST(0)
    ) dut_lsb (
        .clk            (clk),
        .rst            (rst),
        .fifoEmpty      (b_empty),
        .fifoOutData    (64'h0000_0000_0043_4241),
        .fifoOutLen     (4'd3),
        .uartBusy       (1'b0),
        .fifoReadRequest(b_req),
        .uartStartSend  (b_start),
        .uartDataToSend (b_data),
        .active         (b_active),
        .packetDone     (b_done),
        .dropPulse      (b_drop)
    );

    int         b_st_cyc [8];
    logic [7:0] b_st_dat [8];
    int b_n_st = 0;
    always @(negedge clk) begin
        if (b_start && b_n_st < 8) begin
            b_st_cyc[b_n_st] <= cyc;
            b_st_dat[b_n_st] <= b_data;
            b_n_st <= b_n_st + 1;
        end
    end

    // ---------------- checking ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [63:0] d, input logic [LenW-1:0] l);
        ent_data[wr_ptr % 32] = d;
        ent_len[wr_ptr % 32]  = l;
        wr_ptr = wr_ptr + 1;
    endtask

    int t0, tr, s2, bs, bd, br, bdr;

    initial begin
        // Reset state
        tick(2);
        check_eq("rst_active", active, 0);
        check_eq("rst_start", start, 0);
        check_eq("rst_req", rd_req, 0);
        check_eq("rst_data", tx_data, 0);
        rst = 1'b0;
        tick(2);
        check_eq("idle_active", active, 0);
        check_eq("idle_req", rd_req, 0);

        // Len 3, MSB first, busy 4 cycles; LSB-first instance gets the same entry
        busy_len = 4;
        bs = n_st; bd = n_dn; br = n_rd;
        t0 = cyc;
        push(64'h0000_0000_0043_4241, 5'd3);
        b_push = b_push + 1;
        #1 check_eq("t1_req_comb", rd_req, 1);
        tick(40);
        check_eq("t1_nstart", n_st - bs, 3);
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("t1_cyc%0d", i), st_cyc[bs + i] - t0, 2 + i * (6 + Gap));
            check_eq($sformatf("t1_dat%0d", i), st_dat[bs + i], 8'h43 - i);
        end
        check_eq("t1_ndone", n_dn - bd, 1);
        check_eq("t1_done_cyc", dn_cyc[bd] - t0, 19 + 2 * Gap);
        check_eq("t1_rd_cyc", rd_cyc[br] - t0, 0);
        check_eq("lsb_nstart", b_n_st, 3);
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("lsb_cyc%0d", i), b_st_cyc[i] - t0, 2 + 3 * i);
            check_eq($sformatf("lsb_dat%0d", i), b_st_dat[i], 8'h41 + i);
        end

        // Zero-length entry, then len 1 with 0x0D
        bs = n_st; bd = n_dn; br = n_rd; bdr = n_dr;
        t0 = cyc;
        push(64'h0000_0000_0000_00FF, 5'd0);
        push(64'h0000_0000_0000_000D, 5'd1);
        tick(20);
        check_eq("drop_n", n_dr - bdr, 1);
        check_eq("drop_cyc", dr_cyc[bdr] - t0, 1);
        check_eq("drop_nrd", n_rd - br, 2);
        check_eq("drop_rd2_cyc", rd_cyc[br + 1] - t0, 2);
        check_eq("drop_nstart", n_st - bs, 1);
        check_eq("drop_st_cyc", st_cyc[bs] - t0, 4);
        check_eq("drop_st_dat", st_dat[bs], 8'h0D);
        check_eq("drop_done_cyc", dn_cyc[bd] - t0, 9);

        // Over-length entry: len 12 clamps to 8 slots
        busy_len = 0;
        bs = n_st; bd = n_dn;
        t0 = cyc;
        push(64'h1716_1514_1312_1110, 5'd12);
        tick(80);
        check_eq("over_nstart", n_st - bs, 8);
        for (int i = 0; i < 8; i++) begin
            check_eq($sformatf("over_dat%0d", i), st_dat[bs + i], 8'h17 - i);
        end
        check_eq("over_last_cyc", st_cyc[bs + 7] - t0, 2 + 7 * (3 + Gap));
        check_eq("over_done_cyc", dn_cyc[bd] - t0, 4 + 7 * (3 + Gap));

        // Two queued len-2 entries, busy never asserted
        bs = n_st; bd = n_dn; br = n_rd;
        t0 = cyc;
        push(64'h0000_0000_0000_2221, 5'd2);
        push(64'h0000_0000_0000_3231, 5'd2);
        tick(40);
        check_eq("two_nstart", n_st - bs, 4);
        check_eq("two_cyc0", st_cyc[bs] - t0, 2);
        check_eq("two_cyc1", st_cyc[bs + 1] - t0, 5 + Gap);
        check_eq("two_cyc2", st_cyc[bs + 2] - t0, 10 + Gap);
        check_eq("two_cyc3", st_cyc[bs + 3] - t0, 13 + 2 * Gap);
        check_eq("two_dat0", st_dat[bs], 8'h22);
        check_eq("two_dat3", st_dat[bs + 3], 8'h31);
        check_eq("two_ndone", n_dn - bd, 2);
        check_eq("two_done0", dn_cyc[bd] - t0, 7 + Gap);
        check_eq("two_done1", dn_cyc[bd + 1] - t0, 15 + 2 * Gap);
        check_eq("two_rd1_cyc", rd_cyc[br + 1] - t0, 8 + Gap);

        // Reset during WAIT of character 2 of a len-4 entry
        busy_len = 4;
        bs = n_st; bd = n_dn; br = n_rd;
        t0 = cyc;
        push(64'h0000_0000_4443_4241, 5'd4);
        s2 = t0 + 8 + Gap;
        tick(s2 + 3 - t0);
        check_eq("rsw_active_pre", active, 1);
        rst = 1'b1;
        #1;
        check_eq("rsw_active", active, 0);
        check_eq("rsw_start", start, 0);
        check_eq("rsw_data", tx_data, 0);
        check_eq("rsw_done", done, 0);
        check_eq("rsw_drop", drop, 0);
        push(64'h0000_0000_0000_0055, 5'd1);
        #1 check_eq("rsw_req_held", rd_req, 0);
        tick(3);
        tr = cyc;
        rst = 1'b0;
        tick(15);
        check_eq("rsw_nstart", n_st - bs, 3);
        check_eq("rsw_st3_cyc", st_cyc[bs + 2] - tr, 2);
        check_eq("rsw_st3_dat", st_dat[bs + 2], 8'h55);
        check_eq("rsw_nrd", n_rd - br, 2);
        check_eq("rsw_rd2_cyc", rd_cyc[br + 1] - tr, 0);
        check_eq("rsw_ndone", n_dn - bd, 1);
        check_eq("rsw_done_cyc", dn_cyc[bd] - tr, 7);

        check_eq("data_zero_when_idle", n_nz, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
